pwm_period_sched: RTL and testbench

//  Sequences one PWM channel period by period for the GPMC register file.

---
 rtl/pwm_period_sched.sv | 170 +++++++++++++++++
 tb/tb_pwm_period_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_period_sched.sv
// pwm_period_sched: sequences one PWM channel period by period.
//  - Runs the period counter and the period-start IRQ pulse to the DSP.
//  - Double-buffers the switch-on/off compares: a shadow copy is captured at the load point
//    when the DSP toggles its data-valid bit, and is promoted to the active copy at period wrap.
//  - Owns the IDLE/ARMED/RUN/FAULT state machine; too many stale load points in a row force FAULT.
// Ports:
//  clk, rst           system clock, synchronous active-high reset
//  cfg_en, cfg_arm    enable and arm request from the control word
//  cfg_pol            output polarity, 1 = active-low pin
//  cfg_seq            DSP data-valid toggle bit
//  cfg_on, cfg_off    requested switch-on/off counts
//  pwm_out, irq       PWM pin and period-start interrupt (both registered)
//  cnt, act_on/off    period counter and compares in use, for readback
//  state, miss_cnt    FSM state (IDLE=0 ARMED=1 RUN=2 FAULT=3), consecutive stale load points
module pwm_period_sched #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PERIOD_CLK = 50000,
  parameter int unsigned IRQ_LEN    = 500,
  parameter int unsigned LOAD_LEAD  = 50,
  parameter int unsigned MISS_MAX   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic                 cfg_arm,
  input  logic                 cfg_pol,
  input  logic                 cfg_seq,
  input  logic [CNT_WIDTH-1:0] cfg_on,
  input  logic [CNT_WIDTH-1:0] cfg_off,
  output logic                 pwm_out,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] act_on,
  output logic [CNT_WIDTH-1:0] act_off,
  output logic [1:0]           state,
  output logic [3:0]           miss_cnt
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(PERIOD_CLK - 1);
  localparam logic [CNT_WIDTH-1:0] LoadCnt = CNT_WIDTH'(PERIOD_CLK - LOAD_LEAD);
  localparam logic [CNT_WIDTH-1:0] IrqEnd  = CNT_WIDTH'(IRQ_LEN);
  localparam logic [4:0]           MissMax = 5'(MISS_MAX);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] act_on_q, act_on_d, act_off_q, act_off_d;
  logic [CNT_WIDTH-1:0] sh_on_q, sh_on_d, sh_off_q, sh_off_d;
  logic [3:0]           miss_q, miss_d;
  logic                 seq_ref_q, seq_ref_d;
  logic                 pwm_q, pwm_d;
  logic                 irq_q, irq_d;

  logic       load_pt;
  logic       stale;
  logic [4:0] miss_inc;
  logic       in_win;

  assign load_pt  = (state_q == StRun) && (cnt_q == LoadCnt);
  assign stale    = (cfg_seq == seq_ref_q);
  // One bit wider so the threshold compare cannot wrap at miss_q == 15.
  assign miss_inc = {1'b0, miss_q} + 5'd1;

  // Next-state logic; disable overrides everything, including a same-cycle fault trigger.
  always_comb begin
    state_d = state_q;
    if (!cfg_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (cfg_arm) state_d = StArmed;
        StArmed: if (!cfg_arm) state_d = StRun;
        StRun:   if (load_pt && stale && (miss_inc >= MissMax)) state_d = StFault;
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  // Counter, compare double-buffer and stale tracking.
  always_comb begin
    cnt_d     = '0;
    act_on_d  = act_on_q;
    act_off_d = act_off_q;
    sh_on_d   = sh_on_q;
    sh_off_d  = sh_off_q;
    miss_d    = miss_q;
    seq_ref_d = seq_ref_q;
    if ((state_q == StArmed) && (state_d == StRun)) begin
      act_on_d  = '0;
      act_off_d = '0;
      sh_on_d   = '0;
      sh_off_d  = '0;
      miss_d    = '0;
      seq_ref_d = cfg_seq;
    end else if (state_q == StRun) begin
      if (state_d == StRun) begin
        cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CNT_WIDTH'(1);
      end
      if (load_pt) begin
        if (!stale) begin
          sh_on_d   = cfg_on;
          sh_off_d  = cfg_off;
          seq_ref_d = cfg_seq;
          miss_d    = '0;
        end else if (miss_q != 4'hF) begin
          miss_d = miss_q + 4'd1;
        end
      end
      // Promote at the last count so the new compares govern the period from cnt == 0.
      if (cnt_q == LastCnt) begin
        act_on_d  = sh_on_q;
        act_off_d = sh_off_q;
      end
    end
  end

  // on >= off leaves the window empty; off >= PERIOD_CLK keeps it open until wrap.
  assign in_win = (cnt_q >= act_on_q) && (cnt_q < act_off_q);

  always_comb begin
    pwm_d = cfg_pol;
    irq_d = 1'b0;
    if (state_q == StRun) begin
      pwm_d = in_win ^ cfg_pol;
      irq_d = (cnt_q < IrqEnd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      act_on_q  <= '0;
      act_off_q <= '0;
      sh_on_q   <= '0;
      sh_off_q  <= '0;
      miss_q    <= '0;
      seq_ref_q <= 1'b0;
      pwm_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_on_q  <= act_on_d;
      act_off_q <= act_off_d;
      sh_on_q   <= sh_on_d;
      sh_off_q  <= sh_off_d;
      miss_q    <= miss_d;
      seq_ref_q <= seq_ref_d;
      pwm_q     <= pwm_d;
      irq_q     <= irq_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign irq      = irq_q;
  assign cnt      = cnt_q;
  assign act_on   = act_on_q;
  assign act_off  = act_off_q;
  assign state    = state_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_pwm_period_sched.sv
// Bench for pwm_period_sched: directed scenarios plus a random run, all compared each cycle
// against a behavioural model written from the period/load-point rules.
module tb_pwm_period_sched;

  localparam int W    = 16;
  localparam int PER  = 100;
  localparam int IRQL = 10;
  localparam int LEAD = 5;
  localparam int MMAX = 2;

  logic         clk = 1'b0;
  logic         rst, cfg_en, cfg_arm, cfg_pol, cfg_seq;
  logic [W-1:0] cfg_on, cfg_off;
  logic         pwm_out, irq;
  logic [W-1:0] cnt, act_on, act_off;
  logic [1:0]   state;
  logic [3:0]   miss_cnt;

  int checks = 0;
  int errors = 0;

  pwm_period_sched #(
    .CNT_WIDTH (W),
    .PERIOD_CLK(PER),
    .IRQ_LEN   (IRQL),
    .LOAD_LEAD (LEAD),
    .MISS_MAX  (MMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (cfg_en),
    .cfg_arm (cfg_arm),
    .cfg_pol (cfg_pol),
    .cfg_seq (cfg_seq),
    .cfg_on  (cfg_on),
    .cfg_off (cfg_off),
    .pwm_out (pwm_out),
    .irq     (irq),
    .cnt     (cnt),
    .act_on  (act_on),
    .act_off (act_off),
    .state   (state),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0..3, plain integer counter and compare copies.
  int m_state, m_cnt, m_on, m_off, m_shon, m_shoff, m_miss;
  bit m_ref, m_pwm, m_irq;

  task automatic model_step();
    int ns, ncnt;
    bit load, stale, pwm_n, irq_n;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_on = 0; m_off = 0; m_shon = 0; m_shoff = 0;
      m_miss = 0; m_ref = 0; m_pwm = 0; m_irq = 0;
      return;
    end
    load  = (m_state == 2) && (m_cnt == PER - LEAD);
    stale = (cfg_seq == m_ref);
    if (m_state == 2) pwm_n = ((m_cnt >= m_on) && (m_cnt < m_off)) ^ cfg_pol;
    else pwm_n = cfg_pol;
    irq_n = (m_state == 2) && (m_cnt < IRQL);
    ns = m_state;
    if (!cfg_en) ns = 0;
    else if (m_state == 0 && cfg_arm) ns = 1;
    else if (m_state == 1 && !cfg_arm) ns = 2;
    else if (load && stale && (m_miss + 1 >= MMAX)) ns = 3;
    ncnt = 0;
    if (m_state == 1 && ns == 2) begin
      m_on = 0; m_off = 0; m_shon = 0; m_shoff = 0; m_miss = 0; m_ref = cfg_seq;
    end else if (m_state == 2) begin
      if (load) begin
        if (!stale) begin
          m_shon = cfg_on; m_shoff = cfg_off; m_ref = cfg_seq; m_miss = 0;
        end else begin
          m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        end
      end
      if (m_cnt == PER - 1) begin
        m_on = m_shon; m_off = m_shoff;
      end
      if (ns == 2) ncnt = (m_cnt + 1) % PER;
    end
    m_state = ns; m_cnt = ncnt; m_pwm = pwm_n; m_irq = irq_n;
  endtask

  function automatic logic [55:0] dut_vec();
    return {state, cnt, act_on, act_off, miss_cnt, pwm_out, irq};
  endfunction

  function automatic logic [55:0] mdl_vec();
    return {2'(m_state), 16'(m_cnt), 16'(m_on), 16'(m_off), 4'(m_miss), m_pwm, m_irq};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Leaves the DUT freshly in RUN with cnt == 0.
  task automatic start_run(input bit pol);
    rst = 0; cfg_pol = pol; cfg_en = 0; cfg_arm = 0;
    cycle();
    cfg_en = 1; cfg_arm = 1;
    repeat (3) cycle();
    cfg_arm = 0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1; cfg_en = 1; cfg_arm = 0; cfg_pol = 1; cfg_seq = 0; cfg_on = 0; cfg_off = 0;
    cycle();
    checks++;
    if (dut_vec() !== 56'd0) begin
      errors++;
      $display("FAIL reset_state dut=%h exp=%h", dut_vec(), 56'd0);
    end
    rst = 0; cfg_en = 0;
    cycle();
    checks++;
    if (dut_vec() !== mdl_vec() || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_level dut=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_arm_run(input bit pol);
    int act_n, irq_n;
    act_n = 0; irq_n = 0;
    cfg_on = 20; cfg_off = 60;
    start_run(pol);
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL arm_run pol=%0d cyc=%0d dut=%h exp=%h", pol, i, dut_vec(), mdl_vec());
      end
      if (i < 200 && pwm_out !== pol) act_n++;
      if (i < 200 && irq === 1'b1) irq_n++;
      if (m_cnt == 50) cfg_seq = ~cfg_seq;
      cycle();
    end
    checks++;
    if (act_n != 40) begin
      errors++;
      $display("FAIL arm_run_active_len pol=%0d got=%0d exp=40", pol, act_n);
    end
    checks++;
    if (irq_n != 20) begin
      errors++;
      $display("FAIL arm_run_irq_len pol=%0d got=%0d exp=20", pol, irq_n);
    end
    cfg_en = 0;
    cycle();
    cycle();
    checks++;
    if (pwm_out !== pol || state !== 2'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL arm_run_disable pwm=%b state=%0d irq=%b exp pwm=%b state=0 irq=0",
               pwm_out, state, irq, pol);
    end
  endtask

  task automatic test_stale_fault();
    int fault_at;
    fault_at = -1;
    cfg_on = 20; cfg_off = 60;
    start_run(0);
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL stale_fault cyc=%0d dut=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (i == 150) begin
        checks++;
        if (miss_cnt !== 4'd1) begin
          errors++;
          $display("FAIL stale_miss_one got=%0d exp=1", miss_cnt);
        end
      end
      if (fault_at >= 0 && i == fault_at + 1) begin
        checks++;
        if (pwm_out !== 1'b0 || irq !== 1'b0) begin
          errors++;
          $display("FAIL fault_outputs pwm=%b irq=%b exp 0 0", pwm_out, irq);
        end
      end
      if (fault_at < 0 && state === 2'd3) fault_at = i;
      cycle();
    end
    checks++;
    if (fault_at != 196) begin
      errors++;
      $display("FAIL fault_time got=%0d exp=196", fault_at);
    end
    cfg_en = 0;
    cycle();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL fault_to_idle got=%0d exp=0", state);
    end
  endtask

  task automatic test_edge_compares();
    int win_a, win_b;
    win_a = 0; win_b = 0;
    cfg_on = 50; cfg_off = 50;
    start_run(0);
    for (int i = 0; i <= 300; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL edge_cmp cyc=%0d dut=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (i >= 101 && i <= 200 && pwm_out === 1'b1) win_a++;
      if (i >= 201 && pwm_out === 1'b1) win_b++;
      if (i == 50) cfg_seq = ~cfg_seq;
      if (i == 150) begin
        cfg_on = 0; cfg_off = 100; cfg_seq = ~cfg_seq;
      end
      cycle();
    end
    checks++;
    if (win_a != 0) begin
      errors++;
      $display("FAIL equal_cmp_active got=%0d exp=0", win_a);
    end
    checks++;
    if (win_b != 100) begin
      errors++;
      $display("FAIL full_cmp_active got=%0d exp=100", win_b);
    end
  endtask

  task automatic test_late_change();
    cfg_on = 20; cfg_off = 60;
    start_run(0);
    for (int i = 0; i <= 300; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL late_change cyc=%0d dut=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      if (i == 250 || i == 300) begin
        checks++;
        if (act_on !== ((i == 250) ? 16'd20 : 16'd70)) begin
          errors++;
          $display("FAIL late_act_on cyc=%0d got=%0d exp=%0d", i, act_on, (i == 250) ? 20 : 70);
        end
      end
      if (i == 50 || i == 290) cfg_seq = ~cfg_seq;
      if (i == 140) cfg_on = 70;
      cycle();
    end
  endtask

  task automatic test_rst_mid();
    cfg_on = 0; cfg_off = 100;
    start_run(1);
    for (int i = 0; i < 70; i++) cycle();
    checks++;
    if (cnt !== 16'd70 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre cnt=%0d pwm=%b exp 70 1", cnt, pwm_out);
    end
    rst = 1;
    cycle();
    checks++;
    if (state !== 2'd0 || cnt !== '0 || pwm_out !== 1'b0 || irq !== 1'b0 || miss_cnt !== 4'd0)
    begin
      errors++;
      $display("FAIL rst_mid state=%0d cnt=%0d pwm=%b irq=%b miss=%0d exp all 0",
               state, cnt, pwm_out, irq, miss_cnt);
    end
    rst = 0;
  endtask

  task automatic test_random();
    start_run(0);
    for (int i = 0; i < 4000; i++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d dut=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      rst    = ($urandom_range(499) == 0);
      cfg_en = ($urandom_range(299) != 0);
      if ($urandom_range(39) == 0) cfg_arm = ~cfg_arm;
      if ($urandom_range(59) == 0) cfg_seq = ~cfg_seq;
      if ($urandom_range(19) == 0) cfg_on = W'($urandom_range(110));
      if ($urandom_range(19) == 0) cfg_off = W'($urandom_range(110));
      if ($urandom_range(399) == 0) cfg_pol = ~cfg_pol;
      cycle();
    end
  endtask

  initial begin
    rst = 1; cfg_en = 0; cfg_arm = 0; cfg_pol = 0; cfg_seq = 0; cfg_on = 0; cfg_off = 0;
    model_step();
    test_reset();
    test_arm_run(0);
    test_arm_run(1);
    test_stale_fault();
    test_edge_compares();
    test_late_change();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
